// File: rtl/doom58_pkg.sv
// Shared screen geometry, colour constants and FSM state type for the column renderer.
package doom58_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;
    localparam int X_W      = 8;
    localparam int Y_W      = 7;

    typedef logic [2:0] colour_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DRAW = 2'd1,
        DONE = 2'd2
    } cr_state_t;

    localparam colour_t BLACK        = 3'b000;
    localparam colour_t BLUE         = 3'b001;
    localparam colour_t GREEN        = 3'b010;
    localparam colour_t CEIL_COLOUR  = BLUE;
    localparam colour_t FLOOR_COLOUR = GREEN;

    localparam logic [X_W-1:0] X_LIMIT = 8'd160;
    localparam logic [Y_W-1:0] Y_LIMIT = 7'd120;
    localparam logic [Y_W-1:0] Y_LAST  = 7'd119;

endpackage

// File: rtl/column_span_calc.sv
// Combinational wall span: clamps the height to the screen and centres it, odd half-row to the floor.
module column_span_calc
    import doom58_pkg::*;
(
    input  logic [Y_W-1:0] height_i,
    output logic [Y_W-1:0] top_o,
    output logic [Y_W-1:0] bottom_excl_o
);

    logic [Y_W-1:0] h_s;
    logic [Y_W-1:0] gap_s;

    // Clamp, then split the remaining rows with the floor taking the odd one.
    always_comb begin
        if (height_i > Y_LIMIT) begin
            h_s = Y_LIMIT;
        end else begin
            h_s = height_i;
        end
        gap_s         = Y_LIMIT - h_s;
        top_o         = {1'b0, gap_s[Y_W-1:1]};
        bottom_excl_o = top_o + h_s;
    end

endmodule

// File: rtl/column_renderer.sv
// Expands one {x, height, colour} request into 120 framebuffer writes (ceiling, wall, floor).
// Define FLOOR_DITHER_EN for a checkerboard floor.
module column_renderer
    import doom58_pkg::*;
(
    input  logic           clock,
    input  logic           resetn,
    input  logic           req_valid,
    output logic           req_ready,
    input  logic [X_W-1:0] req_x,
    input  logic [Y_W-1:0] req_height,
    input  colour_t        req_colour,
    output logic           done,
    output logic [X_W-1:0] vga_x,
    output logic [Y_W-1:0] vga_y,
    output colour_t        vga_colour,
    output logic           vga_write
);

    cr_state_t      state_q;
    logic           ready_q;
    logic           done_q;
    logic           write_q;
    logic [X_W-1:0] x_q;
    logic [Y_W-1:0] y_q;
    colour_t        colour_q;
    logic [Y_W-1:0] top_q;
    logic [Y_W-1:0] bot_q;
    colour_t        wall_q;

    logic [Y_W-1:0] span_top_s;
    logic [Y_W-1:0] span_bot_s;
    logic           accept_s;

    logic [Y_W-1:0] row_d;
    logic [Y_W-1:0] top_sel_s;
    logic [Y_W-1:0] bot_sel_s;
    colour_t        wall_sel_s;
    colour_t        colour_d;
`ifdef FLOOR_DITHER_EN
    logic [X_W-1:0] x_sel_s;
`endif

    column_span_calc u_span (
        .height_i      (req_height),
        .top_o         (span_top_s),
        .bottom_excl_o (span_bot_s)
    );

    assign accept_s = req_valid & ready_q;

    // Next pixel: on accept it comes straight from the request so row 0 lands the cycle after.
    always_comb begin
        if (state_q == IDLE) begin
            row_d      = 7'd0;
            top_sel_s  = span_top_s;
            bot_sel_s  = span_bot_s;
            wall_sel_s = req_colour;
`ifdef FLOOR_DITHER_EN
            x_sel_s    = req_x;
`endif
        end else begin
            row_d      = y_q + 7'd1;
            top_sel_s  = top_q;
            bot_sel_s  = bot_q;
            wall_sel_s = wall_q;
`ifdef FLOOR_DITHER_EN
            x_sel_s    = x_q;
`endif
        end

        if (row_d < top_sel_s) begin
            colour_d = CEIL_COLOUR;
        end else if (row_d < bot_sel_s) begin
            colour_d = wall_sel_s;
        end else begin
`ifdef FLOOR_DITHER_EN
            if ((x_sel_s[0] ^ row_d[0]) == 1'b0) begin
                colour_d = FLOOR_COLOUR;
            end else begin
                colour_d = BLACK;
            end
`else
            colour_d = FLOOR_COLOUR;
`endif
        end
    end

    // Column FSM with capture registers and registered framebuffer port.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q  <= IDLE;
            ready_q  <= 1'b1;
            done_q   <= 1'b0;
            write_q  <= 1'b0;
            x_q      <= 8'd0;
            y_q      <= 7'd0;
            colour_q <= 3'b000;
            top_q    <= 7'd0;
            bot_q    <= 7'd0;
            wall_q   <= 3'b000;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q  <= 1'b0;
                    write_q <= 1'b0;
                    if (accept_s) begin
                        ready_q <= 1'b0;
                        x_q     <= req_x;
                        top_q   <= span_top_s;
                        bot_q   <= span_bot_s;
                        wall_q  <= req_colour;
                        if (req_x < X_LIMIT) begin
                            state_q  <= DRAW;
                            write_q  <= 1'b1;
                            y_q      <= row_d;
                            colour_q <= colour_d;
                        end else begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                DRAW: begin
                    // Counter holds at the last row; it never wraps back to row 0.
                    if (y_q == Y_LAST) begin
                        write_q <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        y_q      <= row_d;
                        colour_q <= colour_d;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                    done_q  <= 1'b0;
                    write_q <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready  = ready_q;
    assign done       = done_q;
    assign vga_write  = write_q;
    assign vga_x      = x_q;
    assign vga_y      = y_q;
    assign vga_colour = colour_q;

endmodule

// File: tb/tb_column_renderer.sv
// Directed self-checking bench for column_renderer; floor expectations follow FLOOR_DITHER_EN.
module tb_column_renderer;

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic       req_valid = 1'b0;
    logic [7:0] req_x = 8'd0;
    logic [6:0] req_height = 7'd0;
    logic [2:0] req_colour = 3'b000;
    logic       req_ready;
    logic       done;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic       vga_write;

    int checks = 0;
    int errors = 0;

`ifdef FLOOR_DITHER_EN
    localparam bit DITHER = 1'b1;
`else
    localparam bit DITHER = 1'b0;
`endif

    always #5 clock = ~clock;

    column_renderer dut (
        .clock      (clock),
        .resetn     (resetn),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_x      (req_x),
        .req_height (req_height),
        .req_colour (req_colour),
        .done       (done),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .vga_colour (vga_colour),
        .vga_write  (vga_write)
    );

    function automatic logic [2:0] floor_exp(input logic [7:0] x, input int y);
        logic [7:0] yy;
        yy = 8'(y);
        if (DITHER && ((x[0] ^ yy[0]) == 1'b1)) return 3'b000;
        return 3'b010;
    endfunction

    // Called at a negedge; returns at the negedge of the first cycle after the accept edge.
    task automatic send_req(input logic [7:0] x, input logic [6:0] h, input logic [2:0] c, input bit hold);
        int waited;
        waited = 0;
        while (req_ready !== 1'b1 && waited < 300) begin
            @(negedge clock);
            waited++;
        end
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL accept_wait req_ready=%b required 1", req_ready);
        end
        req_x = x;
        req_height = h;
        req_colour = c;
        req_valid = 1'b1;
        @(posedge clock);
        @(negedge clock);
        if (!hold) req_valid = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (3) @(negedge clock);
        checks++;
        if ({req_ready, vga_write, done} !== 3'b100) begin
            errors++;
            $display("FAIL reset_ctrl ready/write/done=%b%b%b required 100", req_ready, vga_write, done);
        end
        checks++;
        if ({vga_x, vga_y, vga_colour} !== 18'd0) begin
            errors++;
            $display("FAIL reset_vga x/y/colour=%0d/%0d/%b required 0/0/000", vga_x, vga_y, vga_colour);
        end
        resetn = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_columns();
        logic [7:0] tx [10] = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd159, 8'd0, 8'd1, 8'd2, 8'd3, 8'd4};
        logic [6:0] th [10] = '{7'd40, 7'd0, 7'd127, 7'd3, 7'd120, 7'd119, 7'd0, 7'd121, 7'd1, 7'd2};
        logic [2:0] tc [10] = '{3'b100, 3'b011, 3'b110, 3'b101, 3'b111, 3'b100, 3'b101, 3'b011, 3'b110, 3'b111};
        int         lo [10] = '{40, 60, 0, 58, 0, 0, 60, 0, 59, 59};
        int         hi [10] = '{80, 60, 120, 61, 120, 119, 60, 120, 60, 61};
        logic [2:0] exp_c;
        for (int e = 0; e < 10; e++) begin
            send_req(tx[e], th[e], tc[e], 1'b0);
            req_x = 8'hAA;
            req_height = 7'd5;
            req_colour = ~tc[e];
            for (int k = 0; k < 120; k++) begin
                if (k < lo[e]) exp_c = 3'b001;
                else if (k < hi[e]) exp_c = tc[e];
                else exp_c = floor_exp(tx[e], k);
                checks++;
                if ({vga_write, vga_x, vga_y, vga_colour, done, req_ready} !==
                    {1'b1, tx[e], 7'(k), exp_c, 1'b0, 1'b0}) begin
                    errors++;
                    $display("FAIL col%0d_row%0d write/x/y/colour/done/ready=%b/%0d/%0d/%b/%b/%b required 1/%0d/%0d/%b/0/0",
                             e, k, vga_write, vga_x, vga_y, vga_colour, done, req_ready, tx[e], k, exp_c);
                end
                @(negedge clock);
            end
            checks++;
            if ({done, vga_write, req_ready} !== 3'b100) begin
                errors++;
                $display("FAIL col%0d_done done/write/ready=%b%b%b required 100", e, done, vga_write, req_ready);
            end
            @(negedge clock);
            checks++;
            if ({done, vga_write, req_ready} !== 3'b001) begin
                errors++;
                $display("FAIL col%0d_ready done/write/ready=%b%b%b required 001", e, done, vga_write, req_ready);
            end
        end
    endtask

    task automatic test_out_of_range();
        logic [7:0] tx [3] = '{8'd160, 8'd170, 8'd255};
        for (int e = 0; e < 3; e++) begin
            send_req(tx[e], 7'd40, 3'b100, 1'b0);
            checks++;
            if ({done, vga_write, req_ready} !== 3'b100) begin
                errors++;
                $display("FAIL oob%0d_done done/write/ready=%b%b%b required 100", e, done, vga_write, req_ready);
            end
            @(negedge clock);
            checks++;
            if ({done, vga_write, req_ready} !== 3'b001) begin
                errors++;
                $display("FAIL oob%0d_idle done/write/ready=%b%b%b required 001", e, done, vga_write, req_ready);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0] exp_c;
        int n;
        send_req(8'd50, 7'd60, 3'b110, 1'b1);
        req_x = 8'd5;
        req_height = 7'd10;
        req_colour = 3'b001;
        for (int k = 0; k < 120; k++) begin
            if (k < 30) exp_c = 3'b001;
            else if (k < 90) exp_c = 3'b110;
            else exp_c = floor_exp(8'd50, k);
            checks++;
            if ({vga_write, vga_x, vga_y, vga_colour, req_ready} !== {1'b1, 8'd50, 7'(k), exp_c, 1'b0}) begin
                errors++;
                $display("FAIL busy_row%0d write/x/y/colour/ready=%b/%0d/%0d/%b/%b required 1/50/%0d/%b/0",
                         k, vga_write, vga_x, vga_y, vga_colour, req_ready, k, exp_c);
            end
            @(negedge clock);
        end
        checks++;
        if ({done, req_ready} !== 2'b10) begin
            errors++;
            $display("FAIL busy_done done/ready=%b%b required 10", done, req_ready);
        end
        @(negedge clock);
        checks++;
        if ({done, req_ready, vga_write} !== 3'b010) begin
            errors++;
            $display("FAIL busy_ready done/ready/write=%b%b%b required 010", done, req_ready, vga_write);
        end
        @(negedge clock);
        req_valid = 1'b0;
        checks++;
        if ({vga_write, vga_x, vga_y, vga_colour} !== {1'b1, 8'd5, 7'd0, 3'b001}) begin
            errors++;
            $display("FAIL b2b_row0 write/x/y/colour=%b/%0d/%0d/%b required 1/5/0/001",
                     vga_write, vga_x, vga_y, vga_colour);
        end
        n = 0;
        while (done !== 1'b1 && n < 200) begin
            @(negedge clock);
            n++;
        end
        checks++;
        if (n != 120) begin
            errors++;
            $display("FAIL b2b_done_latency cycles=%0d required 120", n);
        end
        @(negedge clock);
    endtask

    task automatic test_reset_mid();
        int  writes;
        int  dones;
        bit  order_ok;
        bit  quiet;
        send_req(8'd7, 7'd50, 3'b101, 1'b0);
        repeat (50) @(negedge clock);
        checks++;
        if ({vga_write, vga_y} !== {1'b1, 7'd50}) begin
            errors++;
            $display("FAIL mid_row50 write/y=%b/%0d required 1/50", vga_write, vga_y);
        end
        #1 resetn = 1'b0;
        #1;
        checks++;
        if ({vga_write, done, req_ready, vga_y} !== {1'b0, 1'b0, 1'b1, 7'd0}) begin
            errors++;
            $display("FAIL mid_async write/done/ready/y=%b/%b/%b/%0d required 0/0/1/0",
                     vga_write, done, req_ready, vga_y);
        end
        @(negedge clock);
        @(negedge clock);
        resetn = 1'b1;
        quiet = 1'b1;
        repeat (5) begin
            @(negedge clock);
            if (done !== 1'b0 || vga_write !== 1'b0) quiet = 1'b0;
        end
        checks++;
        if (!quiet) begin
            errors++;
            $display("FAIL mid_no_done saw done or write after reset, required none");
        end
        send_req(8'd3, 7'd127, 3'b100, 1'b0);
        writes = 0;
        dones = 0;
        order_ok = 1'b1;
        for (int i = 0; i < 125; i++) begin
            if (vga_write === 1'b1) begin
                if (vga_y !== 7'(writes) || vga_colour !== 3'b100) order_ok = 1'b0;
                writes++;
            end
            if (done === 1'b1) dones++;
            @(negedge clock);
        end
        checks++;
        if (writes != 120 || dones != 1 || !order_ok) begin
            errors++;
            $display("FAIL mid_redraw writes/dones/order=%0d/%0d/%b required 120/1/1", writes, dones, order_ok);
        end
    endtask

    initial begin
        test_reset();
        test_columns();
        test_out_of_range();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
